// File: rtl/rf_multiport.sv
// Multi-port register file: NRD async read ports, two write ports, debug read, sweep clear.
// Optional same-cycle write-to-read forwarding is compiled in when RF_BYPASS_EN is defined.
module rf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic [ADDR_W-1:0]        reg_sel,
    output logic [DATA_W-1:0]        reg_data,
    output logic                     wr_collide
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   rf [DEPTH];

    logic idle;
    logic wr0;
    logic wr1;

    assign idle  = (state == IDLE);
    assign ready = idle;
    // A clear request in IDLE takes priority over both write ports.
    assign wr0   = idle && !clr_req && we0 && (wa0 != '0);
    assign wr1   = idle && !clr_req && we1 && (wa1 != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR;
            idx        <= ADDR_W'(1);
            wr_collide <= 1'b0;
        end else begin
            wr_collide <= idle && we0 && we1 && (wa0 == wa1) && (wa0 != '0);
            case (state)
                CLEAR: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= ADDR_W'(1);
                    end
                end
                default: begin
                    state <= CLEAR;
                    idx   <= ADDR_W'(1);
                end
            endcase
        end
    end

    // Entry 0 is never stored; the reset edge itself leaves the array untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!idle) begin
                if (idx != '0) begin
                    rf[idx] <= '0;
                end
            end else begin
                if (wr0) begin
                    rf[wa0] <= wd0;
                end
                if (wr1) begin
                    rf[wa1] <= wd1;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] arr_read(input logic [ADDR_W-1:0] a);
        if (idle && (a != '0)) begin
            arr_read = rf[a];
        end else begin
            arr_read = '0;
        end
    endfunction

    function automatic logic [DATA_W-1:0] port_read(input logic [ADDR_W-1:0] a);
`ifdef RF_BYPASS_EN
        if (wr1 && (wa1 == a)) begin
            port_read = wd1;
        end else if (wr0 && (wa0 == a)) begin
            port_read = wd0;
        end else begin
            port_read = arr_read(a);
        end
`else
        port_read = arr_read(a);
`endif
    endfunction

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd_data[k*DATA_W +: DATA_W] = port_read(rd_addr[k*ADDR_W +: ADDR_W]);
    end

    assign reg_data = arr_read(reg_sel);

endmodule
